sync_merge: RTL and testbench
=============================

SYNC_MERGE -- requirements
Module: sync_merge

Interface
REQ-001 Parameter W, default 24: operand width; element width is 2*W.
REQ-002 Parameter DEPTH, default 4: entries per lane FIFO; power of two, minimum 2.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 op1_in  input  W  high-half operand (lane 1).
REQ-006 op1_valid  input  1  op1_in valid this cycle.
REQ-007 op1_ready  output  1  lane 1 can accept a word.
REQ-008 op2_in  input  W  low-half operand (lane 2).
REQ-009 op2_valid  input  1  op2_in valid this cycle.
REQ-010 op2_ready  output  1  lane 2 can accept a word.
REQ-011 element_out  output  2W  merged element {op1, op2}.
REQ-012 out_valid  output  1  element_out holds a valid element.
REQ-013 out_ready  input  1  downstream accepts element_out.
REQ-014 overflow  output  1  sticky error: a valid arrived while its lane was not ready.

Function
REQ-015 Each lane SHALL push its operand into its own FIFO when valid && ready in the same cycle.
REQ-016 opN_ready SHALL be 1 exactly when lane N holds fewer than DEPTH entries; it is a registered/count-derived signal with no combinational path from any input.
REQ-017 When lane N is full, a simultaneous pop SHALL NOT enable a same-cycle push; ready reasserts the cycle after the pop.
REQ-018 A pair pop SHALL occur when both lanes are non-empty and (out_valid == 0 or out_ready == 1); both lanes pop their oldest entry together.
REQ-019 On a pair pop, element_out SHALL load {lane1 head, lane2 head} and out_valid SHALL be 1 on the next cycle.
REQ-020 When out_valid && out_ready and no pair pop occurs, out_valid SHALL clear; element_out SHALL hold its last value.
REQ-021 While out_valid && !out_ready, element_out and out_valid SHALL hold stable.
REQ-022 Latency: if the partner lane is already non-empty and the output is free, a push at edge N yields out_valid at edge N+1 (one cycle).
REQ-023 Pairing SHALL be strictly in arrival order per lane: the k-th op1 pairs with the k-th op2.
REQ-024 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; the occupancy count is log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-025 Push and pop on the same lane in the same cycle (non-full) SHALL leave occupancy unchanged.
REQ-026 opN_valid while opN_ready == 0 SHALL drop the word and set overflow, which remains 1 until reset.
REQ-027 With full output throughput (out_ready held 1), one element per cycle SHALL be sustained.

Reset
REQ-028 On reset assertion, regardless of clock: pointers, counts, out_valid, element_out and overflow SHALL be 0; op1_ready and op2_ready SHALL be 1.
REQ-029 Reset asserted mid-operation SHALL discard all buffered operands and any pending output element.
REQ-030 Deassertion SHALL be synchronised externally; the first push is accepted on the first rising edge after release.

Structure
REQ-031 A shared package SHALL hold OPERAND_W (24), ELEMENT_W (48) and LANE_DEPTH (4) constants.
REQ-032 One sub-module, sync_lane_fifo (W, DEPTH; push, pop, data, full, empty, count), SHALL be instantiated twice.

Verification
REQ-033 Reset, then op1=0x000001 and op2=0x000002 valid in the same cycle -> out_valid next cycle, element_out=0x000001000002.
REQ-034 Push op1 0xA, 0xB, 0xC over 3 cycles, then op2 0x1, 0x2, 0x3 -> elements 0x00000A000001, 0x00000B000002, 0x00000C000003 in order.
REQ-035 out_ready=0, push 4 op1 words -> op1_ready=0; a fifth op1_valid sets overflow=1, and the word is dropped from output.
REQ-036 out_ready=0 with one element pending, pair available -> element_out stable; raise out_ready -> next element the following cycle.
REQ-037 Continuous paired input with out_ready=1 for 16 cycles -> 16 elements back-to-back; pointers wrap without loss.
REQ-038 Assert reset with 3 entries buffered and out_valid=1 -> out_valid=0, both readies=1, overflow=0 immediately.

Source files
------------

// File: rtl/sync_merge_pkg.sv
// ---------------------------------------------------------------
// sync_merge_pkg: shared widths and depth for the operand merger
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package sync_merge_pkg;
  localparam int OPERAND_W  = 24;
  localparam int ELEMENT_W  = 2 * OPERAND_W;
  localparam int LANE_DEPTH = 4;
endpackage

`default_nettype wire

// File: rtl/sync_lane_fifo.sv
// ---------------------------------------------------------------
// sync_lane_fifo: single-clock FIFO holding the operands of one lane
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module sync_lane_fifo
  import sync_merge_pkg::*;
#(
  parameter int W     = OPERAND_W,
  parameter int DEPTH = LANE_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wr_data,
  output logic [W-1:0]           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Full is judged on the registered count, so a pop never frees a slot for a same-cycle push.
  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sync_merge.sv
// ---------------------------------------------------------------
// sync_merge: pairs two operand lanes into {op1, op2} elements
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module sync_merge
  import sync_merge_pkg::*;
#(
  parameter int W     = OPERAND_W,
  parameter int DEPTH = LANE_DEPTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   op1_in,
  input  logic           op1_valid,
  output logic           op1_ready,
  input  logic [W-1:0]   op2_in,
  input  logic           op2_valid,
  output logic           op2_ready,
  output logic [2*W-1:0] element_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           overflow
);

  logic [W-1:0]           head1;
  logic [W-1:0]           head2;
  logic                   full1;
  logic                   full2;
  logic                   empty1;
  logic                   empty2;
  logic [$clog2(DEPTH):0] count1;
  logic [$clog2(DEPTH):0] count2;
  logic                   push1;
  logic                   push2;
  logic                   pair_pop;
  logic                   unused_count;

  assign op1_ready    = !full1;
  assign op2_ready    = !full2;
  assign push1        = op1_valid && op1_ready;
  assign push2        = op2_valid && op2_ready;
  assign pair_pop     = !empty1 && !empty2 && (!out_valid || out_ready);
  assign unused_count = ^{count1, count2};

  sync_lane_fifo #(.W(W), .DEPTH(DEPTH)) u_lane1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push1),
    .pop     (pair_pop),
    .wr_data (op1_in),
    .rd_data (head1),
    .full    (full1),
    .empty   (empty1),
    .count   (count1)
  );

  sync_lane_fifo #(.W(W), .DEPTH(DEPTH)) u_lane2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push2),
    .pop     (pair_pop),
    .wr_data (op2_in),
    .rd_data (head2),
    .full    (full2),
    .empty   (empty2),
    .count   (count2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      element_out <= '0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (pair_pop) begin
        element_out <= {head1, head2};
        out_valid   <= 1'b1;
      end else if (out_ready) begin
        out_valid   <= 1'b0;
      end
      // A word offered to a full lane is lost; remember that until reset.
      if ((op1_valid && !op1_ready) || (op2_valid && !op2_ready)) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_merge.sv
// ---------------------------------------------------------------
// tb_sync_merge: directed self-checking bench for sync_merge
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_sync_merge;

  localparam int W     = 24;
  localparam int DEPTH = 4;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   op1_in;
  logic           op1_valid;
  logic           op1_ready;
  logic [W-1:0]   op2_in;
  logic           op2_valid;
  logic           op2_ready;
  logic [2*W-1:0] element_out;
  logic           out_valid;
  logic           out_ready;
  logic           overflow;

  int errors;
  int checks;

  sync_merge #(.W(W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op1_in      (op1_in),
    .op1_valid   (op1_valid),
    .op1_ready   (op1_ready),
    .op2_in      (op2_in),
    .op2_valid   (op2_valid),
    .op2_ready   (op2_ready),
    .element_out (element_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    op1_in    = '0;
    op1_valid = 1'b0;
    op2_in    = '0;
    op2_valid = 1'b0;
    out_ready = 1'b0;

    // Reset state
    cyc();
    cyc();
    chk("rst_out_valid", {47'd0, out_valid}, 48'd0);
    chk("rst_element",   element_out,        48'd0);
    chk("rst_overflow",  {47'd0, overflow},  48'd0);
    chk("rst_op1_ready", {47'd0, op1_ready}, 48'd1);
    chk("rst_op2_ready", {47'd0, op2_ready}, 48'd1);
    rst_n = 1'b1;

    // Simultaneous pair: element one cycle after the push edge
    op1_in = 24'h000001; op1_valid = 1'b1;
    op2_in = 24'h000002; op2_valid = 1'b1;
    out_ready = 1'b1;
    cyc();
    op1_valid = 1'b0; op2_valid = 1'b0;
    chk("pair_not_yet", {47'd0, out_valid}, 48'd0);
    cyc();
    chk("pair_valid", {47'd0, out_valid}, 48'd1);
    chk("pair_elem",  element_out, 48'h000001000002);
    cyc();
    chk("pair_drain_valid", {47'd0, out_valid}, 48'd0);
    chk("pair_drain_hold",  element_out, 48'h000001000002);

    // op1 leads by three words, op2 follows
    op1_valid = 1'b1;
    op1_in = 24'h00000A; cyc();
    op1_in = 24'h00000B; cyc();
    op1_in = 24'h00000C; cyc();
    op1_valid = 1'b0;
    chk("lead_no_out", {47'd0, out_valid}, 48'd0);
    chk("lead_op1_ready", {47'd0, op1_ready}, 48'd1);
    op2_valid = 1'b1;
    op2_in = 24'h000001; cyc();
    op2_in = 24'h000002; cyc();
    chk("order_e0", element_out, 48'h00000A000001);
    chk("order_v0", {47'd0, out_valid}, 48'd1);
    op2_in = 24'h000003; cyc();
    chk("order_e1", element_out, 48'h00000B000002);
    op2_valid = 1'b0; cyc();
    chk("order_e2", element_out, 48'h00000C000003);
    chk("order_v2", {47'd0, out_valid}, 48'd1);
    cyc();
    chk("order_idle", {47'd0, out_valid}, 48'd0);

    // Fill lane 1, then overflow it
    out_ready = 1'b0;
    op1_valid = 1'b1;
    op1_in = 24'h000011; cyc();
    op1_in = 24'h000012; cyc();
    op1_in = 24'h000013; cyc();
    op1_in = 24'h000014; cyc();
    chk("full_op1_ready", {47'd0, op1_ready}, 48'd0);
    chk("full_no_ovf",    {47'd0, overflow},  48'd0);
    op1_in = 24'h000099; cyc();
    op1_valid = 1'b0;
    chk("ovf_set",       {47'd0, overflow},  48'd1);
    chk("ovf_op1_ready", {47'd0, op1_ready}, 48'd0);
    op2_valid = 1'b1;
    op2_in = 24'h000021; cyc();
    // The pop edge frees a slot but must not accept this op1 word
    op2_in = 24'h000022;
    op1_valid = 1'b1; op1_in = 24'h000015;
    cyc();
    op1_valid = 1'b0;
    chk("stall_e0",        element_out, 48'h000011000021);
    chk("stall_v0",        {47'd0, out_valid}, 48'd1);
    chk("stall_op1_ready", {47'd0, op1_ready}, 48'd1);
    op2_in = 24'h000023; cyc();
    op2_valid = 1'b0;
    chk("stall_hold1", element_out, 48'h000011000021);
    cyc();
    chk("stall_hold2", element_out, 48'h000011000021);
    chk("stall_hold_v", {47'd0, out_valid}, 48'd1);
    out_ready = 1'b1;
    cyc();
    chk("release_e1", element_out, 48'h000012000022);
    cyc();
    chk("release_e2", element_out, 48'h000013000023);
    cyc();
    chk("release_idle", {47'd0, out_valid}, 48'd0);
    op2_valid = 1'b1; op2_in = 24'h000024; cyc();
    op2_valid = 1'b0; cyc();
    chk("dropped_skip_e3", element_out, 48'h000014000024);
    cyc();
    chk("dropped_idle", {47'd0, out_valid}, 48'd0);
    chk("ovf_sticky",   {47'd0, overflow},  48'd1);

    // Back-to-back stream, pointers wrap four times
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        op1_valid = 1'b1; op1_in = 24'h000100 + 24'(i);
        op2_valid = 1'b1; op2_in = 24'h000200 + 24'(i);
      end else begin
        op1_valid = 1'b0; op2_valid = 1'b0;
      end
      cyc();
      if (i >= 1) begin
        chk("stream_v", {47'd0, out_valid}, 48'd1);
        chk("stream_e", element_out, {24'h000100 + 24'(i - 1), 24'h000200 + 24'(i - 1)});
      end
    end
    cyc();
    chk("stream_end", {47'd0, out_valid}, 48'd0);

    // Reset mid-operation with three entries buffered per lane
    out_ready = 1'b0;
    op1_valid = 1'b1; op2_valid = 1'b1;
    op1_in = 24'h000051; op2_in = 24'h000061; cyc();
    op1_in = 24'h000052; op2_in = 24'h000062; cyc();
    op1_in = 24'h000053; op2_in = 24'h000063; cyc();
    op1_in = 24'h000054; op2_in = 24'h000064; cyc();
    op1_valid = 1'b0; op2_valid = 1'b0;
    chk("pre_rst_v", {47'd0, out_valid}, 48'd1);
    chk("pre_rst_e", element_out, 48'h000051000061);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {47'd0, out_valid}, 48'd0);
    chk("arst_op1_ready", {47'd0, op1_ready}, 48'd1);
    chk("arst_op2_ready", {47'd0, op2_ready}, 48'd1);
    chk("arst_overflow",  {47'd0, overflow},  48'd0);
    chk("arst_element",   element_out,        48'd0);
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    op1_valid = 1'b1; op1_in = 24'h000031;
    op2_valid = 1'b1; op2_in = 24'h000041;
    cyc();
    op1_valid = 1'b0; op2_valid = 1'b0;
    cyc();
    chk("post_rst_e", element_out, 48'h000031000041);
    chk("post_rst_v", {47'd0, out_valid}, 48'd1);
    cyc();
    chk("post_rst_flushed", {47'd0, out_valid}, 48'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
